// File: rtl/wall_map.sv
`default_nettype none
// ============================================================================
// Module   : wall_map
// Brief    : Tank-game wall bitmap with a display read port, a game query
//            port, a write port open only outside active lines, and an
//            arena rebuild sequence that runs after reset or on reload.
// Revision : 1.0 - initial release
// ============================================================================
module wall_map #(
    parameter int WIDTH  = 64,
    parameter int HEIGHT = 44
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       i_buzy,
    input  logic [5:0] i_request_x,
    input  logic [5:0] i_request_y,
    output logic       o_is_wall,
    input  logic [5:0] i_query_x,
    input  logic [5:0] i_query_y,
    output logic       o_query_wall,
    input  logic       i_wr_valid,
    input  logic [5:0] i_wr_x,
    input  logic [5:0] i_wr_y,
    input  logic       i_wr_data,
    output logic       o_wr_ready,
    input  logic       i_reload,
    output logic       o_ready
);

    localparam logic [5:0] C_LAST_ROW = 6'(HEIGHT - 1);
    localparam logic [5:0] C_ROW_LIM  = 6'(HEIGHT);

    typedef enum logic [0:0] {
        ST_INIT  = 1'b0,
        ST_READY = 1'b1
    } state_t;

    state_t           state_q, state_d;
    logic [5:0]       r_q, r_d;
    logic [WIDTH-1:0] rows_q [HEIGHT];
    logic [WIDTH-1:0] rows_d [HEIGHT];
    logic             is_wall_q, is_wall_d;
    logic             query_wall_q, query_wall_d;

    logic             w_wr_ready;
    logic             w_wr_commit;
    logic [WIDTH-1:0] w_req_row;
    logic [WIDTH-1:0] w_qry_row;

    // Arena layout: solid border plus a lattice of single-cell pillars.
    function automatic logic [WIDTH-1:0] default_row(input int y);
        logic [WIDTH-1:0] row;
        row = '0;
        for (int x = 0; x < WIDTH; x++) begin
            row[x] = (x == 0) || (x == WIDTH - 1) || (y == 0) || (y == HEIGHT - 1)
                     || (((x % 16) == 8) && ((y % 8) == 4));
        end
        return row;
    endfunction

    assign w_wr_ready  = (state_q == ST_READY) && !i_buzy;
    assign w_wr_commit = i_wr_valid && w_wr_ready && !i_reload && (i_wr_y < C_ROW_LIM);

    // Rows past the field stay all-ones, so out-of-field reads see a wall.
    always_comb begin
        w_req_row = '1;
        w_qry_row = '1;
        for (int row = 0; row < HEIGHT; row++) begin
            if (i_request_y == 6'(row)) w_req_row = rows_q[row];
            if (i_query_y == 6'(row))   w_qry_row = rows_q[row];
        end
    end

    always_comb begin
        state_d      = state_q;
        r_d          = r_q;
        rows_d       = rows_q;
        is_wall_d    = (state_q == ST_INIT) || w_req_row[i_request_x];
        query_wall_d = (state_q == ST_INIT) || w_qry_row[i_query_x];

        if (i_reload) begin
            state_d = ST_INIT;
            r_d     = '0;
        end else if (state_q == ST_INIT) begin
            r_d = r_q + 6'd1;
            if (r_q == C_LAST_ROW) begin
                state_d = ST_READY;
                r_d     = '0;
            end
        end

        for (int row = 0; row < HEIGHT; row++) begin
            if ((state_q == ST_INIT) && (r_q == 6'(row))) begin
                rows_d[row] = default_row(row);
            end
            if (w_wr_commit && (i_wr_y == 6'(row))) begin
                rows_d[row][i_wr_x] = i_wr_data;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_INIT;
            r_q          <= '0;
            rows_q       <= '{default: '0};
            is_wall_q    <= 1'b0;
            query_wall_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            r_q          <= r_d;
            rows_q       <= rows_d;
            is_wall_q    <= is_wall_d;
            query_wall_q <= query_wall_d;
        end
    end

    assign o_is_wall    = is_wall_q;
    assign o_query_wall = query_wall_q;
    assign o_wr_ready   = w_wr_ready;
    assign o_ready      = (state_q == ST_READY);

endmodule
`default_nettype wire

// File: tb/tb_wall_map.sv
`default_nettype none
// ============================================================================
// Module   : tb_wall_map
// Brief    : Self-checking bench for wall_map against a cell-level map model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_wall_map;

    localparam int C_W = 64;
    localparam int C_H = 44;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       i_buzy;
    logic [5:0] i_request_x, i_request_y;
    logic       o_is_wall;
    logic [5:0] i_query_x, i_query_y;
    logic       o_query_wall;
    logic       i_wr_valid;
    logic [5:0] i_wr_x, i_wr_y;
    logic       i_wr_data;
    logic       o_wr_ready;
    logic       i_reload;
    logic       o_ready;

    int n_checks = 0;
    int n_fail   = 0;

    bit wall_m [C_H][C_W];
    bit ref_ready;
    int ref_left;
    bit exp_is_wall, exp_query_wall;

    wall_map #(.WIDTH(C_W), .HEIGHT(C_H)) dut (
        .clk(clk), .rst_n(rst_n), .i_buzy(i_buzy),
        .i_request_x(i_request_x), .i_request_y(i_request_y), .o_is_wall(o_is_wall),
        .i_query_x(i_query_x), .i_query_y(i_query_y), .o_query_wall(o_query_wall),
        .i_wr_valid(i_wr_valid), .i_wr_x(i_wr_x), .i_wr_y(i_wr_y), .i_wr_data(i_wr_data),
        .o_wr_ready(o_wr_ready), .i_reload(i_reload), .o_ready(o_ready)
    );

    always #5 clk = ~clk;

    function automatic bit default_cell(input int x, input int y);
        return (x == 0) || (x == C_W - 1) || (y == 0) || (y == C_H - 1)
               || ((x % 16 == 8) && (y % 8 == 4));
    endfunction

    function automatic bit model_read(input int x, input int y);
        if (!ref_ready || y >= C_H) return 1'b1;
        return wall_m[y][x];
    endfunction

    task automatic model_reset();
        for (int y = 0; y < C_H; y++)
            for (int x = 0; x < C_W; x++) wall_m[y][x] = 1'b0;
        ref_ready = 1'b0;
        ref_left  = C_H;
    endtask

    // Advance model by one edge using the inputs currently driven, then sample.
    task automatic tick();
        bit e1, e2;
        e1 = model_read(int'(i_request_x), int'(i_request_y));
        e2 = model_read(int'(i_query_x), int'(i_query_y));
        if (i_reload) begin
            ref_ready = 1'b0;
            ref_left  = C_H;
        end else if (!ref_ready) begin
            ref_left--;
            if (ref_left == 0) begin
                for (int y = 0; y < C_H; y++)
                    for (int x = 0; x < C_W; x++) wall_m[y][x] = default_cell(x, y);
                ref_ready = 1'b1;
            end
        end else if (i_wr_valid && !i_buzy && int'(i_wr_y) < C_H) begin
            wall_m[int'(i_wr_y)][int'(i_wr_x)] = i_wr_data;
        end
        @(posedge clk);
        #1;
        exp_is_wall    = e1;
        exp_query_wall = e2;
    endtask

    task automatic idle_inputs();
        i_buzy = 0; i_wr_valid = 0; i_wr_x = 0; i_wr_y = 0; i_wr_data = 0; i_reload = 0;
        i_request_x = 0; i_request_y = 0; i_query_x = 0; i_query_y = 0;
    endtask

    task automatic test_reset();
        int first_ready;
        idle_inputs();
        rst_n = 0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        n_checks++; if (o_is_wall !== 1'b0)    begin n_fail++; $display("FAIL reset_is_wall got %b exp 0", o_is_wall); end
        n_checks++; if (o_query_wall !== 1'b0) begin n_fail++; $display("FAIL reset_query_wall got %b exp 0", o_query_wall); end
        n_checks++; if (o_ready !== 1'b0)      begin n_fail++; $display("FAIL reset_ready got %b exp 0", o_ready); end
        n_checks++; if (o_wr_ready !== 1'b0)   begin n_fail++; $display("FAIL reset_wr_ready got %b exp 0", o_wr_ready); end
        rst_n = 1;
        first_ready = -1;
        for (int k = 1; k <= 50; k++) begin
            i_request_x = 6'($urandom_range(0, 63)); i_request_y = 6'($urandom_range(0, 47));
            i_query_x   = 6'($urandom_range(0, 63)); i_query_y   = 6'($urandom_range(0, 47));
            tick();
            n_checks++; if (o_ready !== ref_ready) begin n_fail++; $display("FAIL init_ready edge %0d got %b exp %b", k, o_ready, ref_ready); end
            n_checks++; if (o_is_wall !== exp_is_wall) begin n_fail++; $display("FAIL init_is_wall edge %0d got %b exp %b", k, o_is_wall, exp_is_wall); end
            n_checks++; if (o_query_wall !== exp_query_wall) begin n_fail++; $display("FAIL init_query edge %0d got %b exp %b", k, o_query_wall, exp_query_wall); end
            if (o_ready === 1'b1 && first_ready < 0) first_ready = k;
        end
        n_checks++; if (first_ready !== 44) begin n_fail++; $display("FAIL ready_edge got %0d exp 44", first_ready); end
    endtask

    task automatic test_points();
        int px [7] = '{0, 8, 24, 1, 63, 30, 5};
        int py [7] = '{0, 4, 12, 1, 20, 43, 50};
        bit pe [7] = '{1, 1, 1, 0, 1, 1, 1};
        for (int i = 0; i < 7; i++) begin
            i_request_x = 6'(px[i]); i_request_y = 6'(py[i]);
            i_query_x   = 6'(px[i]); i_query_y   = 6'(py[i]);
            tick();
            n_checks++; if (o_is_wall !== pe[i]) begin n_fail++; $display("FAIL point_is_wall (%0d,%0d) got %b exp %b", px[i], py[i], o_is_wall, pe[i]); end
            n_checks++; if (o_query_wall !== pe[i]) begin n_fail++; $display("FAIL point_query (%0d,%0d) got %b exp %b", px[i], py[i], o_query_wall, pe[i]); end
        end
    endtask

    task automatic test_busy_write();
        i_buzy = 1; i_wr_valid = 1; i_wr_x = 10; i_wr_y = 10; i_wr_data = 1;
        i_query_x = 10; i_query_y = 10;
        #1;
        n_checks++; if (o_wr_ready !== 1'b0) begin n_fail++; $display("FAIL busy_wr_ready got %b exp 0", o_wr_ready); end
        tick();
        tick();
        n_checks++; if (o_query_wall !== 1'b0) begin n_fail++; $display("FAIL busy_blocked_cell got %b exp 0", o_query_wall); end
        i_buzy = 0;
        #1;
        n_checks++; if (o_wr_ready !== 1'b1) begin n_fail++; $display("FAIL idle_wr_ready got %b exp 1", o_wr_ready); end
        tick();
        i_wr_valid = 0;
        tick();
        n_checks++; if (o_query_wall !== 1'b1) begin n_fail++; $display("FAIL busy_then_commit got %b exp 1", o_query_wall); end
    endtask

    task automatic test_rbw();
        i_wr_valid = 1; i_wr_x = 8; i_wr_y = 4; i_wr_data = 0;
        i_request_x = 8; i_request_y = 4;
        tick();
        i_wr_valid = 0;
        n_checks++; if (o_is_wall !== 1'b1) begin n_fail++; $display("FAIL rbw_old got %b exp 1", o_is_wall); end
        tick();
        n_checks++; if (o_is_wall !== 1'b0) begin n_fail++; $display("FAIL rbw_new got %b exp 0", o_is_wall); end
    endtask

    task automatic test_oor_write();
        i_wr_valid = 1; i_wr_x = 5; i_wr_y = 44; i_wr_data = 1;
        #1;
        n_checks++; if (o_wr_ready !== 1'b1) begin n_fail++; $display("FAIL oor_wr_ready got %b exp 1", o_wr_ready); end
        tick();
        i_wr_valid = 0;
        i_query_x = 5; i_query_y = 43;
        tick();
        n_checks++; if (o_query_wall !== 1'b1) begin n_fail++; $display("FAIL oor_row43 got %b exp 1", o_query_wall); end
        i_query_y = 42;
        tick();
        n_checks++; if (o_query_wall !== 1'b0) begin n_fail++; $display("FAIL oor_row42 got %b exp 0", o_query_wall); end
    endtask

    task automatic test_random();
        for (int k = 0; k < 600; k++) begin
            i_buzy      = ($urandom_range(0, 3) == 0);
            i_wr_valid  = $urandom_range(0, 1);
            i_wr_x      = 6'($urandom_range(0, 63));
            i_wr_y      = 6'($urandom_range(0, 47));
            i_wr_data   = $urandom_range(0, 1);
            i_reload    = ($urandom_range(0, 199) == 0);
            i_request_x = ($urandom_range(0, 1) == 1) ? i_wr_x : 6'($urandom_range(0, 63));
            i_request_y = ($urandom_range(0, 1) == 1) ? i_wr_y : 6'($urandom_range(0, 47));
            i_query_x   = 6'($urandom_range(0, 63));
            i_query_y   = 6'($urandom_range(0, 47));
            #1;
            n_checks++; if (o_wr_ready !== (ref_ready && !i_buzy)) begin n_fail++; $display("FAIL rnd_wr_ready cyc %0d got %b exp %b", k, o_wr_ready, ref_ready && !i_buzy); end
            tick();
            n_checks++; if (o_is_wall !== exp_is_wall) begin n_fail++; $display("FAIL rnd_is_wall cyc %0d got %b exp %b", k, o_is_wall, exp_is_wall); end
            n_checks++; if (o_query_wall !== exp_query_wall) begin n_fail++; $display("FAIL rnd_query cyc %0d got %b exp %b", k, o_query_wall, exp_query_wall); end
            n_checks++; if (o_ready !== ref_ready) begin n_fail++; $display("FAIL rnd_ready cyc %0d got %b exp %b", k, o_ready, ref_ready); end
        end
        idle_inputs();
        for (int k = 0; k < 50 && !ref_ready; k++) tick();
        n_checks++; if (o_ready !== 1'b1) begin n_fail++; $display("FAIL rnd_settle_ready got %b exp 1", o_ready); end
    endtask

    task automatic test_reload();
        i_wr_valid = 1; i_wr_x = 10; i_wr_y = 10; i_wr_data = 1;
        tick();
        i_wr_x = 8; i_wr_y = 4; i_wr_data = 0;
        tick();
        i_wr_x = 20; i_wr_y = 20; i_wr_data = 1; i_reload = 1;
        tick();
        i_wr_valid = 0; i_reload = 0;
        for (int k = 1; k <= 44; k++) begin
            i_request_x = 6'($urandom_range(0, 63)); i_request_y = 6'($urandom_range(1, 42));
            i_query_x   = 6'($urandom_range(1, 62)); i_query_y   = 6'($urandom_range(1, 42));
            tick();
            n_checks++; if (o_ready !== (k == 44)) begin n_fail++; $display("FAIL reload_ready k %0d got %b exp %b", k, o_ready, k == 44); end
            n_checks++; if (o_is_wall !== 1'b1) begin n_fail++; $display("FAIL reload_is_wall k %0d got %b exp 1", k, o_is_wall); end
            n_checks++; if (o_query_wall !== 1'b1) begin n_fail++; $display("FAIL reload_query k %0d got %b exp 1", k, o_query_wall); end
        end
        for (int y = 0; y < C_H; y++) begin
            for (int x = 0; x < C_W; x++) begin
                i_request_x = 6'(x);       i_request_y = 6'(y);
                i_query_x   = 6'(C_W - 1 - x); i_query_y = 6'(C_H - 1 - y);
                tick();
                n_checks++; if (o_is_wall !== default_cell(x, y)) begin n_fail++; $display("FAIL scan_is_wall (%0d,%0d) got %b exp %b", x, y, o_is_wall, default_cell(x, y)); end
                n_checks++; if (o_query_wall !== default_cell(C_W - 1 - x, C_H - 1 - y)) begin n_fail++; $display("FAIL scan_query (%0d,%0d) got %b", C_W - 1 - x, C_H - 1 - y, o_query_wall); end
            end
        end
    endtask

    task automatic test_async_reset();
        int first_ready;
        idle_inputs();
        rst_n = 0;
        model_reset();
        @(posedge clk);
        #1;
        rst_n = 1;
        i_request_x = 5; i_request_y = 5; i_query_x = 6; i_query_y = 6;
        repeat (20) tick();
        n_checks++; if (o_is_wall !== 1'b1) begin n_fail++; $display("FAIL midinit_is_wall got %b exp 1", o_is_wall); end
        #2;
        rst_n = 0;
        model_reset();
        #1;
        n_checks++; if (o_is_wall !== 1'b0)    begin n_fail++; $display("FAIL async_is_wall got %b exp 0", o_is_wall); end
        n_checks++; if (o_query_wall !== 1'b0) begin n_fail++; $display("FAIL async_query got %b exp 0", o_query_wall); end
        n_checks++; if (o_ready !== 1'b0)      begin n_fail++; $display("FAIL async_ready got %b exp 0", o_ready); end
        n_checks++; if (o_wr_ready !== 1'b0)   begin n_fail++; $display("FAIL async_wr_ready got %b exp 0", o_wr_ready); end
        @(posedge clk);
        #1;
        rst_n = 1;
        first_ready = -1;
        for (int k = 1; k <= 50; k++) begin
            tick();
            if (o_ready === 1'b1 && first_ready < 0) first_ready = k;
        end
        n_checks++; if (first_ready !== 44) begin n_fail++; $display("FAIL async_ready_edge got %0d exp 44", first_ready); end
        i_request_x = 56; i_request_y = 36; i_query_x = 57; i_query_y = 36;
        tick();
        n_checks++; if (o_is_wall !== 1'b1)    begin n_fail++; $display("FAIL post_async_pillar got %b exp 1", o_is_wall); end
        n_checks++; if (o_query_wall !== 1'b0) begin n_fail++; $display("FAIL post_async_open got %b exp 0", o_query_wall); end
    endtask

    initial begin
        test_reset();
        test_points();
        test_busy_write();
        test_rbw();
        test_oor_write();
        test_random();
        test_reload();
        test_async_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
